uart_tx_byte: RTL



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_byte.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and framing constants.
// Also used by the matching receiver.
package uart_pkg;
   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int UART_DATA_BITS       = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every bit starts with a full period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear || (r_count == LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign bit_end = (r_count == LAST) && !clear;

endmodule

// File: rtl/uart_tx_byte.sv
// UART byte transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// One byte per valid/ready handshake; in_ready is high only in IDLE.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   tx_state_t  r_state;
   logic [7:0] r_shreg;
   logic [2:0] r_bit_idx;
   logic       r_parity;
   logic       r_tx;
   logic       r_busy;
   logic       w_bit_end;
   logic       w_clear;

   // The counter idles at zero so the start bit gets a full period after transfer.
   assign w_clear  = (r_state == IDLE);
   assign in_ready = (r_state == IDLE) && !rst;
   assign tx       = r_tx;
   assign busy     = r_busy;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_clear),
      .bit_end(w_bit_end)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (in_valid) begin
                  r_shreg   <= in_data;
                  r_parity  <= (PARITY_ODD != 0) ? ~^in_data : ^in_data;
                  r_bit_idx <= '0;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_tx    <= r_shreg[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_shreg <= {1'b0, r_shreg[7:1]};
                  if (r_bit_idx == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        r_tx    <= r_parity;
                        r_state <= PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                     end
                  end else begin
                     r_tx      <= r_shreg[1];
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
